// File: rtl/uart_rx_fifo_if.sv
// Bundle of the receiver handshake, CPU read port and status flags of uart_rx_fifo.
// The slave modport is the FIFO side and the master modport is the driving side.
interface uart_rx_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ack;
  logic                  rd_en;
  logic [7:0]            rd_data;
  logic                  clr_ovf;
  logic [DEPTH_LOG2-1:0] thresh;
  logic [DEPTH_LOG2:0]   count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  intr;

  modport slave (
    input  rx_valid, rx_data, rd_en, clr_ovf, thresh,
    output rx_ack, rd_data, count, empty, full, overflow, intr
  );

  modport master (
    output rx_valid, rx_data, rd_en, clr_ovf, thresh,
    input  rx_ack, rd_data, count, empty, full, overflow, intr
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between a UART receiver (level valid / ack handshake) and a CPU
// data register: one push per rx_valid assertion, one pop per rd_en rising edge.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic            clock,
  input  logic            rstb,
  uart_rx_fifo_if.slave   bus
);
  localparam int unsigned        DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic {
    W_IDLE,
    W_ACK
  } wstate_e;

  wstate_e               wstate_q;
  logic                  rx_ack_q;
  logic                  rd_en_q;
  logic                  overflow_q;
  logic                  intr_q;
  logic [7:0]            rd_data_q;
  logic [DEPTH_LOG2-1:0] wptr_q;
  logic [DEPTH_LOG2-1:0] rptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_d;
  logic [7:0]            mem_q [DEPTH];

  logic empty;
  logic full;
  logic push_try;
  logic pop_req;
  logic do_pop;
  logic do_push;
  logic ovf_set;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a byte alongside it.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_FULL);
    push_try = (wstate_q == W_IDLE) && bus.rx_valid;
    pop_req  = bus.rd_en && !rd_en_q;
    do_pop   = pop_req && !empty;
    do_push  = push_try && (!full || pop_req);
    ovf_set  = push_try && full && !pop_req;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge rstb) begin
    if (!rstb) begin
      wstate_q   <= W_IDLE;
      rx_ack_q   <= 1'b0;
      rd_en_q    <= 1'b0;
      overflow_q <= 1'b0;
      intr_q     <= 1'b0;
      rd_data_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (bus.rx_valid) begin
            wstate_q <= W_ACK;
            rx_ack_q <= 1'b1;
          end
        end
        W_ACK: begin
          if (!bus.rx_valid) begin
            wstate_q <= W_IDLE;
            rx_ack_q <= 1'b0;
          end
        end
        default: begin
          wstate_q <= W_IDLE;
          rx_ack_q <= 1'b0;
        end
      endcase

      rd_en_q <= bus.rd_en;
      if (pop_req) begin
        rd_data_q <= empty ? 8'h00 : mem_q[rptr_q];
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
      if (do_push) begin
        wptr_q <= wptr_q + PTR_ONE;
      end
      count_q <= count_d;

      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow_q <= 1'b0;
      end

      intr_q <= (count_q > {1'b0, bus.thresh});
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wptr_q] <= bus.rx_data;
    end
  end

  assign bus.rx_ack   = rx_ack_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.count    = count_q;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.overflow = overflow_q;
  assign bus.intr     = intr_q;
endmodule
